// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multi-port register file.
// Imported by regfile_mp and rf_scoreboard.
package regfile_pkg;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

    localparam int RF_DATA_W = 16;
    localparam int RF_ADDR_W = 3;

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Pending-result scoreboard: one bit per register, set by reserve,
// cleared by write or by the bulk-clear sweep, with two lookup ports.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sweep_i,
    input  logic [ADDR_W-1:0] sweep_idx_i,
    input  logic              set_i,
    input  logic [ADDR_W-1:0] set_idx_i,
    input  logic              clr_i,
    input  logic [ADDR_W-1:0] clr_idx_i,
    input  logic [ADDR_W-1:0] rd_a_i,
    input  logic [ADDR_W-1:0] rd_b_i,
    output logic              pend_a_o,
    output logic              pend_b_o
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;

    // Set is applied after clear so a new producer wins over a retiring one.
    always_comb begin
        pend_d = pend_q;
        if (sweep_i) begin
            pend_d[sweep_idx_i] = 1'b0;
        end else begin
            if (clr_i) pend_d[clr_idx_i] = 1'b0;
            if (set_i) pend_d[set_idx_i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) pend_q <= '0;
        else       pend_q <= pend_d;
    end

    assign pend_a_o = pend_q[rd_a_i];
    assign pend_b_o = pend_q[rd_b_i];

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: 1 write, 2 async reads, pending scoreboard,
// bulk-clear sweep. Define REGFILE_BYPASS_EN for write-through reads.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write,
    input  logic [ADDR_W-1:0] writenum,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] readnum_a,
    output logic [DATA_W-1:0] data_out_a,
    input  logic [ADDR_W-1:0] readnum_b,
    output logic [DATA_W-1:0] data_out_b,
    input  logic              reserve,
    input  logic [ADDR_W-1:0] reservenum,
    output logic              pending_a,
    output logic              pending_b,
    input  logic              clear_req,
    output logic              busy
);

    localparam int NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

    rf_state_t         state_q;
    logic [ADDR_W-1:0] idx_q;
    logic              busy_q;
    logic [DATA_W-1:0] regs_q [NREGS];

    logic              wr_en;
    logic              rs_en;
    logic              sb_pend_a;
    logic              sb_pend_b;

    assign wr_en = write & ~busy_q;
    assign rs_en = reserve & ~busy_q;
    assign busy  = busy_q;

    // Sweep FSM: the exit test precedes the increment, so idx never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RF_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                RF_IDLE: begin
                    if (clear_req) begin
                        state_q <= RF_CLEAR;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                RF_CLEAR: begin
                    if (idx_q == LAST_IDX) begin
                        state_q <= RF_IDLE;
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        idx_q <= idx_q + ADDR_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (busy_q) begin
            regs_q[idx_q] <= '0;
        end else if (write) begin
            regs_q[writenum] <= data_in;
        end
    end

    rf_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_sb (
        .clk         (clk),
        .reset       (reset),
        .sweep_i     (busy_q),
        .sweep_idx_i (idx_q),
        .set_i       (rs_en),
        .set_idx_i   (reservenum),
        .clr_i       (wr_en),
        .clr_idx_i   (writenum),
        .rd_a_i      (readnum_a),
        .rd_b_i      (readnum_b),
        .pend_a_o    (sb_pend_a),
        .pend_b_o    (sb_pend_b)
    );

`ifdef REGFILE_BYPASS_EN
    logic hit_a;
    logic hit_b;

    assign hit_a = wr_en & (writenum == readnum_a);
    assign hit_b = wr_en & (writenum == readnum_b);

    // On a hit, pending shows the post-edge value: only a same-index reserve keeps it set.
    assign data_out_a = hit_a ? data_in : regs_q[readnum_a];
    assign data_out_b = hit_b ? data_in : regs_q[readnum_b];
    assign pending_a  = hit_a ? (rs_en & (reservenum == readnum_a)) : sb_pend_a;
    assign pending_b  = hit_b ? (rs_en & (reservenum == readnum_b)) : sb_pend_b;
`else
    assign data_out_a = regs_q[readnum_a];
    assign data_out_b = regs_q[readnum_b];
    assign pending_a  = sb_pend_a;
    assign pending_b  = sb_pend_b;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp against a behavioural array model.
// Covers both the default 16x8 build and a 32-bit, 16-entry build.
module tb_regfile_mp;

    localparam int NR = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        write = 1'b0;
    logic [2:0]  writenum = '0;
    logic [15:0] data_in = '0;
    logic [2:0]  readnum_a = '0;
    logic [15:0] data_out_a;
    logic [2:0]  readnum_b = '0;
    logic [15:0] data_out_b;
    logic        reserve = 1'b0;
    logic [2:0]  reservenum = '0;
    logic        pending_a;
    logic        pending_b;
    logic        clear_req = 1'b0;
    logic        busy;

    logic        w_write = 1'b0;
    logic [3:0]  w_wn = '0;
    logic [31:0] w_din = '0;
    logic [3:0]  w_ra = '0;
    logic [31:0] w_da;
    logic [3:0]  w_rb = '0;
    logic [31:0] w_db;
    logic        w_res = 1'b0;
    logic [3:0]  w_rn = '0;
    logic        w_pa;
    logic        w_pb;
    logic        w_cr = 1'b0;
    logic        w_busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] mdl_r [NR];
    logic        mdl_p [NR];
    int          mdl_left = 0;

    always #5 clk = ~clk;

    regfile_mp dut (
        .clk        (clk),
        .reset      (reset),
        .write      (write),
        .writenum   (writenum),
        .data_in    (data_in),
        .readnum_a  (readnum_a),
        .data_out_a (data_out_a),
        .readnum_b  (readnum_b),
        .data_out_b (data_out_b),
        .reserve    (reserve),
        .reservenum (reservenum),
        .pending_a  (pending_a),
        .pending_b  (pending_b),
        .clear_req  (clear_req),
        .busy       (busy)
    );

    regfile_mp #(
        .DATA_W (32),
        .ADDR_W (4)
    ) dut_w (
        .clk        (clk),
        .reset      (reset),
        .write      (w_write),
        .writenum   (w_wn),
        .data_in    (w_din),
        .readnum_a  (w_ra),
        .data_out_a (w_da),
        .readnum_b  (w_rb),
        .data_out_b (w_db),
        .reserve    (w_res),
        .reservenum (w_rn),
        .pending_a  (w_pa),
        .pending_b  (w_pb),
        .clear_req  (w_cr),
        .busy       (w_busy)
    );

    // Reference model: applies one clock edge using the inputs held at that edge.
    task automatic cycle();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < NR; i++) begin
                mdl_r[i] = '0;
                mdl_p[i] = 1'b0;
            end
            mdl_left = 0;
        end else if (mdl_left > 0) begin
            mdl_r[NR - mdl_left] = '0;
            mdl_p[NR - mdl_left] = 1'b0;
            mdl_left--;
        end else begin
            if (write) begin
                mdl_r[writenum] = data_in;
                mdl_p[writenum] = 1'b0;
            end
            if (reserve) mdl_p[reservenum] = 1'b1;
            if (clear_req) mdl_left = NR;
        end
        #1;
    endtask

    task automatic idle();
        write     = 1'b0;
        reserve   = 1'b0;
        clear_req = 1'b0;
    endtask

    function automatic logic [15:0] exp_d(input logic [2:0] ra);
`ifdef REGFILE_BYPASS_EN
        if (write && mdl_left == 0 && writenum == ra) return data_in;
`endif
        return mdl_r[ra];
    endfunction

    function automatic logic exp_p(input logic [2:0] ra);
`ifdef REGFILE_BYPASS_EN
        if (write && mdl_left == 0 && writenum == ra)
            return reserve && reservenum == ra;
`endif
        return mdl_p[ra];
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        idle();
        cycle();
        cycle();
        reset = 1'b0;
        for (int i = 0; i < NR; i++) begin
            readnum_a = 3'(i);
            readnum_b = 3'(NR - 1 - i);
            @(negedge clk);
            n_tests++;
            if ({data_out_a, data_out_b, pending_a, pending_b, busy} !== 35'd0) begin
                n_fail++;
                $display("FAIL reset_r%0d: got a=%h b=%h pa=%b pb=%b busy=%b want all 0",
                         i, data_out_a, data_out_b, pending_a, pending_b, busy);
            end
            cycle();
        end
    endtask

    task automatic test_write_read();
        idle();
        write = 1'b1; writenum = 3'd3; data_in = 16'h1234;
        cycle();
        writenum = 3'd5; data_in = 16'hABCD;
        cycle();
        idle();
        readnum_a = 3'd3;
        readnum_b = 3'd5;
        @(negedge clk);
        n_tests++;
        if (data_out_a !== 16'h1234 || data_out_b !== 16'hABCD) begin
            n_fail++;
            $display("FAIL write_read: got a=%h b=%h want 1234 abcd", data_out_a, data_out_b);
        end
        n_tests++;
        if ({pending_a, pending_b} !== 2'b00) begin
            n_fail++;
            $display("FAIL write_read_pend: got %b%b want 00", pending_a, pending_b);
        end
        cycle();
    endtask

    task automatic test_reserve();
        idle();
        reserve = 1'b1; reservenum = 3'd2;
        cycle();
        idle();
        readnum_a = 3'd2;
        readnum_b = 3'd2;
        @(negedge clk);
        n_tests++;
        if ({pending_a, pending_b} !== 2'b11) begin
            n_fail++;
            $display("FAIL reserve_set: got %b%b want 11", pending_a, pending_b);
        end
        cycle();
        write = 1'b1; writenum = 3'd2; data_in = 16'h00FF;
        cycle();
        idle();
        @(negedge clk);
        n_tests++;
        if ({pending_a, pending_b} !== 2'b00 || data_out_a !== 16'h00FF || data_out_b !== 16'h00FF) begin
            n_fail++;
            $display("FAIL reserve_release: got pend=%b%b a=%h b=%h want 00 00ff 00ff",
                     pending_a, pending_b, data_out_a, data_out_b);
        end
        cycle();
        write = 1'b1; writenum = 3'd2; data_in = 16'h0F0F;
        reserve = 1'b1; reservenum = 3'd2;
        cycle();
        idle();
        @(negedge clk);
        n_tests++;
        if ({pending_a, pending_b} !== 2'b11 || data_out_a !== 16'h0F0F) begin
            n_fail++;
            $display("FAIL reserve_wins: got pend=%b%b a=%h want 11 0f0f",
                     pending_a, pending_b, data_out_a);
        end
        cycle();
        write = 1'b1; writenum = 3'd6; data_in = 16'h6666;
        reserve = 1'b1; reservenum = 3'd1;
        cycle();
        idle();
        readnum_a = 3'd6;
        readnum_b = 3'd1;
        @(negedge clk);
        n_tests++;
        if ({pending_a, pending_b} !== 2'b01 || data_out_a !== 16'h6666) begin
            n_fail++;
            $display("FAIL reserve_split: got pend=%b%b a=%h want 01 6666",
                     pending_a, pending_b, data_out_a);
        end
        cycle();
    endtask

    task automatic test_bypass();
        logic [15:0] want;
        idle();
        write = 1'b1; writenum = 3'd4; data_in = 16'h1111;
        cycle();
        readnum_a = 3'd4;
        readnum_b = 3'd0;
        data_in = 16'h5A5A;
        @(negedge clk);
`ifdef REGFILE_BYPASS_EN
        want = 16'h5A5A;
`else
        want = 16'h1111;
`endif
        n_tests++;
        if (data_out_a !== want || pending_a !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_same: got a=%h pa=%b want %h 0", data_out_a, pending_a, want);
        end
        cycle();
        idle();
        @(negedge clk);
        n_tests++;
        if (data_out_a !== 16'h5A5A) begin
            n_fail++;
            $display("FAIL bypass_next: got a=%h want 5a5a", data_out_a);
        end
        cycle();
    endtask

    task automatic fill_all();
        for (int i = 0; i < NR; i++) begin
            write      = 1'b1;
            writenum   = 3'(i);
            data_in    = 16'($urandom_range(1, 16'hFFFF));
            reserve    = 1'(i);
            reservenum = 3'(i);
            cycle();
        end
        idle();
    endtask

    task automatic test_clear();
        int bcount = 0;
        fill_all();
        clear_req = 1'b1;
        cycle();
        clear_req = 1'b0;
        for (int k = 0; k < 12; k++) begin
            readnum_a = 3'(k);
            readnum_b = 3'(k + 5);
            write   = (k == 2);
            writenum = 3'd7; data_in = 16'hBEEF;
            reserve = (k == 2);
            reservenum = 3'd0;
            clear_req = (k == 4);
            @(negedge clk);
            if (busy === 1'b1) bcount++;
            n_tests++;
            if ({data_out_a, data_out_b, pending_a, pending_b, busy} !==
                {exp_d(readnum_a), exp_d(readnum_b), exp_p(readnum_a), exp_p(readnum_b), mdl_left > 0}) begin
                n_fail++;
                $display("FAIL clear_step%0d: got a=%h b=%h pa=%b pb=%b busy=%b want a=%h b=%h pa=%b pb=%b busy=%b",
                         k, data_out_a, data_out_b, pending_a, pending_b, busy,
                         exp_d(readnum_a), exp_d(readnum_b), exp_p(readnum_a), exp_p(readnum_b), mdl_left > 0);
            end
            cycle();
        end
        idle();
        n_tests++;
        if (bcount !== NR) begin
            n_fail++;
            $display("FAIL clear_busy_len: got %0d cycles want %0d", bcount, NR);
        end
        for (int i = 0; i < NR; i++) begin
            readnum_a = 3'(i);
            readnum_b = 3'(i);
            @(negedge clk);
            n_tests++;
            if ({data_out_a, data_out_b, pending_a, pending_b} !== 34'd0) begin
                n_fail++;
                $display("FAIL clear_after_r%0d: got a=%h b=%h pa=%b pb=%b want 0",
                         i, data_out_a, data_out_b, pending_a, pending_b);
            end
            cycle();
        end
    endtask

    task automatic test_reset_mid_clear();
        fill_all();
        clear_req = 1'b1;
        cycle();
        clear_req = 1'b0;
        for (int s = 0; s < 3; s++) cycle();
        readnum_a = 3'd3;
        readnum_b = 3'd2;
        @(negedge clk);
        n_tests++;
        if (data_out_a !== mdl_r[3] || data_out_b !== 16'h0000 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midclear_partial: got a=%h b=%h busy=%b want %h 0000 1",
                     data_out_a, data_out_b, busy, mdl_r[3]);
        end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midclear_busy: got %b want 0", busy);
        end
        for (int i = 0; i < NR; i++) begin
            readnum_a = 3'(i);
            readnum_b = 3'(NR - 1 - i);
            #1;
            n_tests++;
            if ({data_out_a, data_out_b, pending_a, pending_b} !== 34'd0) begin
                n_fail++;
                $display("FAIL midclear_r%0d: got a=%h b=%h pa=%b pb=%b want 0",
                         i, data_out_a, data_out_b, pending_a, pending_b);
            end
        end
        cycle();
        write = 1'b1; writenum = 3'd1; data_in = 16'h7777;
        cycle();
        idle();
        readnum_a = 3'd1;
        @(negedge clk);
        n_tests++;
        if (data_out_a !== 16'h7777 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midclear_idle: got a=%h busy=%b want 7777 0", data_out_a, busy);
        end
        cycle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            write      = 1'($urandom);
            writenum   = 3'($urandom);
            data_in    = 16'($urandom);
            reserve    = ($urandom_range(0, 2) == 0);
            reservenum = 3'($urandom);
            readnum_a  = 3'($urandom);
            readnum_b  = 3'($urandom);
            clear_req  = ($urandom_range(0, 39) == 0);
            @(negedge clk);
            n_tests++;
            if ({data_out_a, data_out_b, pending_a, pending_b, busy} !==
                {exp_d(readnum_a), exp_d(readnum_b), exp_p(readnum_a), exp_p(readnum_b), mdl_left > 0}) begin
                n_fail++;
                $display("FAIL random_%0d: got a=%h b=%h pa=%b pb=%b busy=%b want a=%h b=%h pa=%b pb=%b busy=%b",
                         n, data_out_a, data_out_b, pending_a, pending_b, busy,
                         exp_d(readnum_a), exp_d(readnum_b), exp_p(readnum_a), exp_p(readnum_b), mdl_left > 0);
            end
            cycle();
        end
        idle();
        for (int n = 0; n < NR + 2; n++) cycle();
    endtask

    task automatic test_wide();
        int bcount = 0;
        w_write = 1'b1; w_wn = 4'd15; w_din = 32'hDEADBEEF;
        @(posedge clk); #1;
        w_write = 1'b0;
        w_ra = 4'd15;
        w_rb = 4'd15;
        @(negedge clk);
        n_tests++;
        if (w_da !== 32'hDEADBEEF || w_db !== 32'hDEADBEEF || {w_pa, w_pb} !== 2'b00) begin
            n_fail++;
            $display("FAIL wide_rw: got a=%h b=%h pend=%b%b want deadbeef deadbeef 00",
                     w_da, w_db, w_pa, w_pb);
        end
        @(posedge clk); #1;
        w_cr = 1'b1;
        @(posedge clk); #1;
        w_cr = 1'b0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (w_busy === 1'b1) bcount++;
        end
        n_tests++;
        if (bcount !== 16) begin
            n_fail++;
            $display("FAIL wide_busy_len: got %0d cycles want 16", bcount);
        end
        n_tests++;
        if (w_da !== 32'd0 || w_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wide_cleared: got a=%h busy=%b want 0 0", w_da, w_busy);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_reserve();
        test_bypass();
        test_clear();
        test_reset_mid_clear();
        test_random();
        test_wide();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
